// File: rtl/reg_file_sb.sv
// Dual-write-port register file with write-through bypass and a per-register
// busy scoreboard for in-flight long-latency writes.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rf_ra0,
    input  logic [ADDR_W-1:0] rf_ra1,
    output logic [DATA_W-1:0] rf_rd0,
    output logic [DATA_W-1:0] rf_rd1,
    output logic              rf_busy0,
    output logic              rf_busy1,
    input  logic              rf_we0,
    input  logic [ADDR_W-1:0] rf_wa0,
    input  logic [DATA_W-1:0] rf_wd0,
    input  logic              rf_we1,
    input  logic [ADDR_W-1:0] rf_wa1,
    input  logic [DATA_W-1:0] rf_wd1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_wa,
    input  logic              sb_flush,
    input  logic [ADDR_W-1:0] dbg_reg_ra,
    output logic [DATA_W-1:0] dbg_reg_rd
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_we0_eff;
    logic              w_we1_eff;
    logic              w_we1_commit;
    logic              w_sb_eff;

    assign w_we0_eff    = rf_we0 && !(ZERO_REG != 0 && rf_wa0 == '0);
    assign w_we1_eff    = rf_we1 && !(ZERO_REG != 0 && rf_wa1 == '0);
    // Port 0 owns the address when both ports target the same register.
    assign w_we1_commit = w_we1_eff && !(w_we0_eff && rf_wa0 == rf_wa1);
    assign w_sb_eff     = sb_set && !(ZERO_REG != 0 && sb_wa == '0);

    // Set is applied after the write clears so a same-address collision stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (sb_flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_we0_eff) w_busy_nxt[rf_wa0] = 1'b0;
            if (w_we1_eff) w_busy_nxt[rf_wa1] = 1'b0;
            if (w_sb_eff)  w_busy_nxt[sb_wa]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_we0_eff)    r_mem[rf_wa0] <= rf_wd0;
            if (w_we1_commit) r_mem[rf_wa1] <= rf_wd1;
            r_busy <= w_busy_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = r_mem[ra];
        if (BYPASS != 0) begin
            if (w_we0_eff && rf_wa0 == ra)      v = rf_wd0;
            else if (w_we1_eff && rf_wa1 == ra) v = rf_wd1;
        end
        if (ZERO_REG != 0 && ra == '0) v = '0;
        return v;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
        logic b;
        b = r_busy[ra];
        if (BYPASS != 0 && ((w_we0_eff && rf_wa0 == ra) || (w_we1_eff && rf_wa1 == ra)))
            b = 1'b0;
        if (ZERO_REG != 0 && ra == '0) b = 1'b0;
        return b;
    endfunction

    always_comb begin
        rf_rd0   = read_data(rf_ra0);
        rf_rd1   = read_data(rf_ra1);
        rf_busy0 = read_busy(rf_ra0);
        rf_busy1 = read_busy(rf_ra1);
    end

    assign dbg_reg_rd = r_mem[dbg_reg_ra];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing instance and a non-bypassing
// instance share the same stimulus.
module tb_reg_file_sb;
    logic        clk;
    logic        rst;
    logic [4:0]  rf_ra0, rf_ra1, rf_wa0, rf_wa1, sb_wa, dbg_reg_ra;
    logic [31:0] rf_wd0, rf_wd1;
    logic        rf_we0, rf_we1, sb_set, sb_flush;
    logic [31:0] rd0, rd1, dbg_rd;
    logic        busy0, busy1;
    logic [31:0] nb_rd0, nb_rd1, nb_dbg_rd;
    logic        nb_busy0, nb_busy1;

    int n_total;
    int n_bad;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
        .rf_rd0(rd0), .rf_rd1(rd1),
        .rf_busy0(busy0), .rf_busy1(busy1),
        .rf_we0(rf_we0), .rf_wa0(rf_wa0), .rf_wd0(rf_wd0),
        .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
        .sb_set(sb_set), .sb_wa(sb_wa), .sb_flush(sb_flush),
        .dbg_reg_ra(dbg_reg_ra), .dbg_reg_rd(dbg_rd)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
        .rf_rd0(nb_rd0), .rf_rd1(nb_rd1),
        .rf_busy0(nb_busy0), .rf_busy1(nb_busy1),
        .rf_we0(rf_we0), .rf_wa0(rf_wa0), .rf_wd0(rf_wd0),
        .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
        .sb_set(sb_set), .sb_wa(sb_wa), .sb_flush(sb_flush),
        .dbg_reg_ra(dbg_reg_ra), .dbg_reg_rd(nb_dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rf_we0 = 1'b0; rf_we1 = 1'b0; sb_set = 1'b0; sb_flush = 1'b0;
        rf_wa0 = '0; rf_wa1 = '0; rf_wd0 = '0; rf_wd1 = '0; sb_wa = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle();
        rf_ra0 = '0; rf_ra1 = '0; dbg_reg_ra = '0;
        rst = 1'b1;
        #3;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_busy0", {31'b0, busy0}, 32'h0);
        // write during reset: bypassed to the read port, never stored
        rf_we0 = 1'b1; rf_wa0 = 5'd6; rf_wd0 = 32'h77; rf_ra1 = 5'd6; dbg_reg_ra = 5'd6;
        #1;
        chk("rst_bypass_rd1", rd1, 32'h77);
        step();
        chk("rst_write_ignored", dbg_rd, 32'h0);
        rst = 1'b0;
        step();

        // async reset between edges
        rf_we0 = 1'b1; rf_wa0 = 5'd5; rf_wd0 = 32'hDEADBEEF;
        sb_set = 1'b1; sb_wa = 5'd5;
        rf_ra0 = 5'd5; dbg_reg_ra = 5'd5;
        #1;
        chk("x5_bypass", rd0, 32'hDEADBEEF);
        step();
        chk("x5_stored", dbg_rd, 32'hDEADBEEF);
        chk("x5_busy_set_wins", {31'b0, busy0}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rd0", rd0, 32'h0);
        chk("async_rst_busy0", {31'b0, busy0}, 32'h0);
        chk("async_rst_dbg", dbg_rd, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // dual-write conflict
        rf_we0 = 1'b1; rf_wa0 = 5'd7; rf_wd0 = 32'h11;
        rf_we1 = 1'b1; rf_wa1 = 5'd7; rf_wd1 = 32'h22;
        rf_ra0 = 5'd7; dbg_reg_ra = 5'd7;
        #1;
        chk("conf_bypass_rd0", rd0, 32'h11);
        step();
        chk("conf_stored", dbg_rd, 32'h11);
        rf_we0 = 1'b1; rf_wa0 = 5'd7; rf_wd0 = 32'h11;
        rf_we1 = 1'b1; rf_wa1 = 5'd8; rf_wd1 = 32'h22;
        rf_ra1 = 5'd8;
        #1;
        chk("dual_bypass_rd1", rd1, 32'h22);
        step();
        chk("dual_x7", dbg_rd, 32'h11);
        dbg_reg_ra = 5'd8;
        #1;
        chk("dual_x8", dbg_rd, 32'h22);

        // zero register
        rf_we0 = 1'b1; rf_wa0 = 5'd0; rf_wd0 = 32'h1234;
        rf_we1 = 1'b1; rf_wa1 = 5'd0; rf_wd1 = 32'h1234;
        sb_set = 1'b1; sb_wa = 5'd0;
        rf_ra0 = 5'd0; dbg_reg_ra = 5'd0;
        #1;
        chk("x0_rd0", rd0, 32'h0);
        chk("x0_busy0", {31'b0, busy0}, 32'h0);
        step();
        chk("x0_dbg", dbg_rd, 32'h0);
        chk("x0_busy0_after", {31'b0, busy0}, 32'h0);

        // scoreboard lifecycle
        sb_set = 1'b1; sb_wa = 5'd3; rf_ra1 = 5'd3;
        #1;
        chk("sb_not_yet_busy", {31'b0, busy1}, 32'h0);
        step();
        chk("sb_busy_next", {31'b0, busy1}, 32'h1);
        step();
        step();
        chk("sb_busy_held", {31'b0, busy1}, 32'h1);
        rf_we1 = 1'b1; rf_wa1 = 5'd3; rf_wd1 = 32'hABCD;
        #1;
        chk("sb_retire_busy1", {31'b0, busy1}, 32'h0);
        chk("sb_retire_rd1", rd1, 32'hABCD);
        chk("sb_nb_busy_until_edge", {31'b0, nb_busy1}, 32'h1);
        step();
        chk("sb_cleared", {31'b0, busy1}, 32'h0);
        chk("sb_nb_cleared", {31'b0, nb_busy1}, 32'h0);
        chk("sb_stored_rd1", rd1, 32'hABCD);

        // set/clear collision then flush
        sb_set = 1'b1; sb_wa = 5'd4;
        rf_we0 = 1'b1; rf_wa0 = 5'd4; rf_wd0 = 32'h44;
        rf_ra0 = 5'd4;
        step();
        chk("coll_busy4", {31'b0, busy0}, 32'h1);
        chk("coll_data4", rd0, 32'h44);
        sb_flush = 1'b1; sb_set = 1'b1; sb_wa = 5'd9; rf_ra1 = 5'd9;
        #1;
        chk("flush_pending_busy4", {31'b0, busy0}, 32'h1);
        step();
        chk("flush_busy4", {31'b0, busy0}, 32'h0);
        chk("flush_busy9", {31'b0, busy1}, 32'h0);

        // non-bypass instance sees old data until the edge
        rf_we0 = 1'b1; rf_wa0 = 5'd2; rf_wd0 = 32'h55; rf_ra0 = 5'd2;
        #1;
        chk("nb_old_rd0", nb_rd0, 32'h0);
        chk("byp_new_rd0", rd0, 32'h55);
        step();
        chk("nb_new_rd0", nb_rd0, 32'h55);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
